// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared definitions for the ALU control sequencer: the 4-bit
//                ALU operation codes, the R-type function and I-type opcode
//                values it decodes, the counter width and the FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    // ALU operation codes (low 4 bits of alu_ctr)
    localparam logic [3:0] c_alu_and   = 4'b0000;
    localparam logic [3:0] c_alu_or    = 4'b0001;
    localparam logic [3:0] c_alu_add   = 4'b0010;
    localparam logic [3:0] c_alu_xor   = 4'b0011;
    localparam logic [3:0] c_alu_passb = 4'b0100;
    localparam logic [3:0] c_alu_sub   = 4'b0110;
    localparam logic [3:0] c_alu_slt   = 4'b0111;
    localparam logic [3:0] c_alu_sll   = 4'b1000;
    localparam logic [3:0] c_alu_srl   = 4'b1001;
    localparam logic [3:0] c_alu_sra   = 4'b1010;
    localparam logic [3:0] c_alu_sltu  = 4'b1011;
    localparam logic [3:0] c_alu_nor   = 4'b1100;
    localparam logic [3:0] c_alu_mult  = 4'b1101;
    localparam logic [3:0] c_alu_div   = 4'b1110;

    // R-type function field values
    localparam logic [5:0] c_fn_add  = 6'b100000;
    localparam logic [5:0] c_fn_addu = 6'b100001;
    localparam logic [5:0] c_fn_sub  = 6'b100010;
    localparam logic [5:0] c_fn_subu = 6'b100011;
    localparam logic [5:0] c_fn_and  = 6'b100100;
    localparam logic [5:0] c_fn_or   = 6'b100101;
    localparam logic [5:0] c_fn_xor  = 6'b100110;
    localparam logic [5:0] c_fn_nor  = 6'b100111;
    localparam logic [5:0] c_fn_slt  = 6'b101010;
    localparam logic [5:0] c_fn_sltu = 6'b101011;
    localparam logic [5:0] c_fn_sll  = 6'b000000;
    localparam logic [5:0] c_fn_srl  = 6'b000010;
    localparam logic [5:0] c_fn_sra  = 6'b000011;
    localparam logic [5:0] c_fn_mult = 6'b011000;
    localparam logic [5:0] c_fn_div  = 6'b011010;

    // I-type opcode values
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_sltiu = 6'b001011;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_xori  = 6'b001110;
    localparam logic [5:0] c_op_lui   = 6'b001111;

    // Latency counter width: holds up to 63, enough for a 64-cycle operation
    localparam int c_cnt_w = 6;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_decode
//  Description : Purely combinational decoder from opcode / function field to
//                the 4-bit ALU code. Unmapped encodings decode to ADD with the
//                illegal flag raised.
//  Ports       : i_op[5:0]       I-type opcode
//                i_func[5:0]     R-type function field
//                i_mux_select    1 = decode i_func, 0 = decode i_op
//                o_code[3:0]     ALU operation code
//                o_illegal       encoding not recognised
//                o_is_multi      code is a multi-cycle MULT or DIV
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    input  logic       i_mux_select,
    output logic [3:0] o_code,
    output logic       o_illegal,
    output logic       o_is_multi
);

    always_comb begin
        o_code     = c_alu_add;
        o_illegal  = 1'b0;
        o_is_multi = 1'b0;
        if (i_mux_select) begin
            case (i_func)
                c_fn_add, c_fn_addu: o_code = c_alu_add;
                c_fn_sub, c_fn_subu: o_code = c_alu_sub;
                c_fn_and:            o_code = c_alu_and;
                c_fn_or:             o_code = c_alu_or;
                c_fn_xor:            o_code = c_alu_xor;
                c_fn_nor:            o_code = c_alu_nor;
                c_fn_slt:            o_code = c_alu_slt;
                c_fn_sltu:           o_code = c_alu_sltu;
                c_fn_sll:            o_code = c_alu_sll;
                c_fn_srl:            o_code = c_alu_srl;
                c_fn_sra:            o_code = c_alu_sra;
                c_fn_mult: begin
                    o_code     = c_alu_mult;
                    o_is_multi = 1'b1;
                end
                c_fn_div: begin
                    o_code     = c_alu_div;
                    o_is_multi = 1'b1;
                end
                default:             o_illegal = 1'b1;
            endcase
        end else begin
            case (i_op)
                c_op_addi, c_op_addiu,
                c_op_lw, c_op_sw:    o_code = c_alu_add;
                c_op_beq, c_op_bne:  o_code = c_alu_sub;
                c_op_slti:           o_code = c_alu_slt;
                c_op_sltiu:          o_code = c_alu_sltu;
                c_op_andi:           o_code = c_alu_and;
                c_op_ori:            o_code = c_alu_or;
                c_op_xori:           o_code = c_alu_xor;
                c_op_lui:            o_code = c_alu_passb;
                default:             o_illegal = 1'b1;
            endcase
        end
    end

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_seq
//  Description : Registered ALU control sequencer. Accepts decode requests
//                over a valid/ready handshake, presents the ALU code on a
//                valid/ready result port, and stretches MULT / DIV requests
//                over a parameterised number of cycles.
//  Ports       : clk, reset          clock, synchronous active-high reset
//                flush               abort held / in-flight work
//                in_valid, in_ready  request handshake
//                op, func, mux_select instruction fields and R/I select
//                out_valid, out_ready result handshake
//                alu_ctr[CTRL_W-1:0] registered ALU code (upper bits zero)
//                illegal             held code came from an unmapped encoding
//                busy                multi-cycle operation in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic              mux_select,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctr,
    output logic              illegal,
    output logic              busy
);

    localparam logic [c_cnt_w-1:0] c_mul_load = c_cnt_w'(MUL_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_load = c_cnt_w'(DIV_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 r_out_valid;
    logic                 w_out_valid_nxt;
    logic [CTRL_W-1:0]    r_alu_ctr;
    logic [CTRL_W-1:0]    w_alu_ctr_nxt;
    logic                 r_illegal;
    logic                 w_illegal_nxt;

    logic [3:0]           w_code;
    logic                 w_illegal;
    logic                 w_is_multi;
    logic                 w_in_ready;
    logic                 w_accept;

    alu_ctrl_decode u_decode (
        .i_op         (op),
        .i_func       (func),
        .i_mux_select (mux_select),
        .o_code       (w_code),
        .o_illegal    (w_illegal),
        .o_is_multi   (w_is_multi)
    );

    // Ready only when idle and the result slot is empty or being drained this
    // cycle; the latter gives back-to-back single-cycle throughput.
    assign w_in_ready = (r_state == ST_IDLE) & ~flush & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & w_in_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_out_valid_nxt = r_out_valid;
        w_alu_ctr_nxt   = r_alu_ctr;
        w_illegal_nxt   = r_illegal;

        if (flush) begin
            w_state_nxt     = ST_IDLE;
            w_cnt_nxt       = '0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_alu_ctr_nxt = CTRL_W'(w_code);
                        w_illegal_nxt = w_illegal;
                        if (w_is_multi) begin
                            // Result is withheld until the count expires
                            w_state_nxt     = ST_MULTI;
                            w_cnt_nxt       = (w_code == c_alu_div) ? c_div_load : c_mul_load;
                            w_out_valid_nxt = 1'b0;
                        end else begin
                            w_out_valid_nxt = 1'b1;
                        end
                    end else if (r_out_valid && out_ready) begin
                        w_out_valid_nxt = 1'b0;
                    end
                end
                ST_MULTI: begin
                    if (r_cnt == '0) begin
                        w_state_nxt     = ST_IDLE;
                        w_out_valid_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_alu_ctr   <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_alu_ctr   <= w_alu_ctr_nxt;
            r_illegal   <= w_illegal_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign alu_ctr   = r_alu_ctr;
    assign illegal   = r_illegal;
    assign busy      = (r_state == ST_MULTI);

endmodule : alu_ctrl_seq
`default_nettype wire

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter CTRL_W, default 4, width of alu_ctr; legal range 4..8.
REQ-002 Parameter MUL_CYCLES, default 4, execute latency of MULT in cycles; legal range 2..64.
REQ-003 Parameter DIV_CYCLES, default 32, execute latency of DIV in cycles; legal range 2..64.
REQ-004 Clock: clk, input, 1 bit; the single clock, rising edge.
REQ-005 Reset: reset, input, 1 bit; synchronous, active-high.
REQ-006 Port flush, input, 1 bit: abort all held or in-flight work.
REQ-007 Ports in_valid (input, 1) and in_ready (output, 1): decode-request handshake.
REQ-008 Port op, input, 6 bits: instruction opcode, bit 5 = MSB.
REQ-009 Port func, input, 6 bits: R-type function field, bit 5 = MSB.
REQ-010 Port mux_select, input, 1 bit: 1 selects func decode (R-type), 0 selects op decode (I-type).
REQ-011 Ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-012 Port alu_ctr, output, CTRL_W bits: registered ALU control code.
REQ-013 Port illegal, output, 1 bit: the held code came from an undefined op/func.
REQ-014 Port busy, output, 1 bit: a multi-cycle operation is counting.

Function
REQ-015 Codes (4 LSBs; upper bits zero): AND=0000, OR=0001, ADD=0010, XOR=0011, PASSB=0100, SUB=0110, SLT=0111, SLL=1000, SRL=1001, SRA=1010, SLTU=1011, NOR=1100, MULT=1101, DIV=1110.
REQ-016 R-type func map: 100000/100001->ADD; 100010/100011->SUB; 100100->AND; 100101->OR; 100110->XOR; 100111->NOR; 101010->SLT; 101011->SLTU; 000000->SLL; 000010->SRL; 000011->SRA; 011000->MULT; 011010->DIV.
REQ-017 I-type op map: 001000/001001/100011/101011->ADD; 000100/000101->SUB; 001010->SLT; 001011->SLTU; 001100->AND; 001101->OR; 001110->XOR; 001111->PASSB.
REQ-018 Any unmapped code -> alu_ctr=ADD, illegal=1; otherwise illegal=0.
REQ-019 in_ready = (state==IDLE) & ~flush & (~out_valid | out_ready).
REQ-020 A request is accepted on a rising edge where in_valid & in_ready; alu_ctr and illegal load on that edge.
REQ-021 FSM states IDLE, MULTI. IDLE->MULTI on acceptance of MULT or DIV; MULTI->IDLE when counter reaches 0.
REQ-022 Single-cycle code: out_valid=1 on the cycle after acceptance (latency 1).
REQ-023 MULT/DIV: counter loads MUL_CYCLES-1 or DIV_CYCLES-1; busy=1 while in MULTI; counter decrements each cycle; out_valid rises on the cycle after the counter reaches 0 (latency = MUL_CYCLES or DIV_CYCLES).
REQ-024 out_valid, alu_ctr and illegal hold stable until out_valid & out_ready.
REQ-025 Simultaneous out_ready handshake and new acceptance: new result replaces old with no bubble (back-to-back throughput 1/cycle for single-cycle codes).
REQ-026 flush: next cycle out_valid=0, busy=0, state=IDLE, counter=0; no acceptance in a flush cycle; flush takes priority over every other event.
REQ-027 in_valid while busy or while output stalled: not accepted; op/func ignored.

Reset
REQ-028 reset takes priority over flush and all inputs.
REQ-029 After reset: state=IDLE, counter=0, out_valid=0, busy=0, illegal=0, alu_ctr=0; in_ready=1 on the first cycle after reset deasserts.
REQ-030 Reset mid-MULTI discards the operation; no out_valid is produced for it.

Structure
REQ-031 Shared package alu_ctrl_pkg holds the 14 ALU code constants, the op and func opcode constants, and the FSM state enum.
REQ-032 One sub-module alu_ctrl_decode: purely combinational op/func/mux_select -> 4-bit code, illegal, is_multi; the parent holds all registers.

Verification
REQ-033 mux_select=1, func=100010, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, alu_ctr=0110, illegal=0.
REQ-034 mux_select=0, op=001111 -> alu_ctr=0100; op=111111 -> alu_ctr=0010, illegal=1.
REQ-035 func=011010, DIV_CYCLES=32 -> busy=1 for 32 cycles, in_ready=0 throughout, out_valid at cycle 32, alu_ctr=1110.
REQ-036 out_ready=0 with result held, in_valid=1 -> in_ready=0, alu_ctr unchanged; raise out_ready -> new request accepted in the same cycle.
REQ-037 Start MULT, flush at cycle 2 -> busy=0 and out_valid=0 next cycle, no result; next request accepted normally.
REQ-038 Assert reset during MULTI -> all outputs at reset values next cycle; in_ready=1 after reset deasserts.
